// File: rtl/w_mem_pkg.sv
// w_mem_pkg: shared definitions for the banked weight-memory controller.
//   - default parameter values for the controller and its banks
//   - addr_bank / addr_row: split a flat word address {bank, row}
//   - bank_req_t: per-bank request {en, we, row, data, be}; fields are sized
//     for the widest supported bank (REQ_*), and users fill/slice the low bits
package w_mem_pkg;

  localparam int DEF_N_BANKS      = 2;
  localparam int DEF_BANK_WORDS   = 512;
  localparam int DEF_WORD_BITS    = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  // Widest bank the request struct can describe.
  localparam int REQ_ROW_W  = 16;
  localparam int REQ_DATA_W = 128;
  localparam int REQ_BE_W   = REQ_DATA_W / 8;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [REQ_ROW_W-1:0]  row;
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_BE_W-1:0]   be;
  } bank_req_t;

  function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int unsigned row_w);
    return addr >> row_w;
  endfunction

  function automatic logic [31:0] addr_row(input logic [31:0] addr, input int unsigned row_w);
    return addr & ((32'd1 << row_w) - 32'd1);
  endfunction

endpackage

// File: rtl/w_mem_bank.sv
// w_mem_bank: single-port synchronous SRAM bank model.
// Ports:
//   clk        - clock
//   scan_en_in - scan/test mode; blocks all array accesses while high
//   i_ceb      - chip enable, active-low
//   i_web      - write enable, active-low (high with i_ceb low = read)
//   i_a        - row address
//   i_d        - write data
//   i_bweb     - bit write mask, active-low (0 = bit is written)
//   o_q        - read data, valid one cycle after a read, held otherwise
module w_mem_bank
  import w_mem_pkg::*;
#(
  parameter int WORDS = DEF_BANK_WORDS,
  parameter int AW    = $clog2(DEF_BANK_WORDS),
  parameter int WIDTH = DEF_WORD_BITS
) (
  input  logic             clk,
  input  logic             scan_en_in,
  input  logic             i_ceb,
  input  logic             i_web,
  input  logic [AW-1:0]    i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_bweb,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_q;

  // Array contents are not reset; Q only changes on a read.
  always_ff @(posedge clk) begin
    if (!i_ceb && !scan_en_in) begin
      if (!i_web) r_mem[i_a] <= (r_mem[i_a] & i_bweb) | (i_d & ~i_bweb);
      else        r_q        <= r_mem[i_a];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/w_mem_banked_ctrl.sv
// w_mem_banked_ctrl: banked weight memory between the weight loader (write
// port) and the PE-array weight fetch (read port).
// Ports:
//   clk, reset (async, active-low), scan_en_in (to every bank)
//   rd_priority                - 0: write wins a same-bank conflict, 1: read wins
//   wr_valid/wr_ready, wr_addr, wr_data, wr_be      - write request
//   rd_req_valid/rd_req_ready, rd_addr              - read request
//   rd_rsp_valid/rd_rsp_ready, rd_rsp_data          - read response (1-cycle latency)
//   addr_err                   - sticky, accepted access to bank >= N_BANKS
//   conflict_cnt               - saturating count of same-bank conflict cycles
module w_mem_banked_ctrl
  import w_mem_pkg::*;
#(
  parameter int N_BANKS      = DEF_N_BANKS,
  parameter int BANK_WORDS   = DEF_BANK_WORDS,
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int BANK_AW     = $clog2(BANK_WORDS),
  localparam int BANK_SEL_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int ADDR_W      = BANK_SEL_W + BANK_AW,
  localparam int BE_W        = WORD_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en_in,
  input  logic                 rd_priority,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic [BE_W-1:0]      wr_be,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_rsp_valid,
  input  logic                 rd_rsp_ready,
  output logic [WORD_BITS-1:0] rd_rsp_data,
  output logic                 addr_err,
  output logic [15:0]          conflict_cnt
);

  localparam int LOSS_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LOSS_W-1:0]     LOSS_MAX = LOSS_W'(STARVE_LIMIT);
  // One extra bit so N_BANKS itself is representable for the range check.
  localparam logic [BANK_SEL_W:0]   NB_LIM   = (BANK_SEL_W + 1)'(N_BANKS);

  logic [BANK_SEL_W-1:0] w_wr_bank, w_rd_bank;
  logic [BANK_AW-1:0]    w_wr_row, w_rd_row;
  logic                  w_wr_oob, w_rd_oob;
  logic                  w_conflict, w_rd_wins, w_rsp_stall, w_wr_acc, w_rd_acc;
  logic [WORD_BITS-1:0]  w_bank_q [N_BANKS];
  logic [WORD_BITS-1:0]  w_q_sel;

  logic [LOSS_W-1:0]     r_wr_loss, r_rd_loss;
  logic                  r_rsp_valid, r_rsp_oob, r_hold_valid, r_addr_err;
  logic [BANK_SEL_W-1:0] r_rsp_bank;
  logic [WORD_BITS-1:0]  r_hold_data;
  logic [15:0]           r_conflict_cnt;

  assign w_wr_bank = BANK_SEL_W'(addr_bank(32'(wr_addr), BANK_AW));
  assign w_rd_bank = BANK_SEL_W'(addr_bank(32'(rd_addr), BANK_AW));
  assign w_wr_row  = BANK_AW'(addr_row(32'(wr_addr), BANK_AW));
  assign w_rd_row  = BANK_AW'(addr_row(32'(rd_addr), BANK_AW));
  assign w_wr_oob  = {1'b0, w_wr_bank} >= NB_LIM;
  assign w_rd_oob  = {1'b0, w_rd_bank} >= NB_LIM;

  // Arbitration never looks at rd_rsp_ready, so wr_ready has no path from it.
  // A starved write is checked first so the guard has a fixed tie-break.
  always_comb begin
    w_conflict = wr_valid && rd_req_valid && (w_wr_bank == w_rd_bank);
    if (r_wr_loss >= LOSS_MAX)      w_rd_wins = 1'b0;
    else if (r_rd_loss >= LOSS_MAX) w_rd_wins = 1'b1;
    else                            w_rd_wins = rd_priority;
  end

  assign w_rsp_stall  = r_rsp_valid && !rd_rsp_ready;
  assign wr_ready     = !(w_conflict && w_rd_wins);
  assign rd_req_ready = !w_rsp_stall && !(w_conflict && !w_rd_wins);
  assign w_wr_acc     = wr_valid && wr_ready;
  assign w_rd_acc     = rd_req_valid && rd_req_ready;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    bank_req_t            w_req;
    logic                 w_wr_hit, w_rd_hit;
    logic [WORD_BITS-1:0] w_bweb;
    logic                 w_unused_req;

    assign w_wr_hit = w_wr_acc && (w_wr_bank == BANK_SEL_W'(b));
    assign w_rd_hit = w_rd_acc && (w_rd_bank == BANK_SEL_W'(b));

    always_comb begin
      w_req      = '0;
      w_req.en   = w_wr_hit || w_rd_hit;
      w_req.we   = w_wr_hit;
      w_req.row  = REQ_ROW_W'(w_wr_hit ? w_wr_row : w_rd_row);
      w_req.data = REQ_DATA_W'(wr_data);
      w_req.be   = REQ_BE_W'(wr_be);
    end

    always_comb begin
      w_bweb = '0;
      for (int j = 0; j < BE_W; j++) w_bweb[8*j +: 8] = {8{~w_req.be[j]}};
    end

    // Upper struct bits beyond this bank's geometry are always zero.
    assign w_unused_req = ^w_req;

    w_mem_bank #(
      .WORDS (BANK_WORDS),
      .AW    (BANK_AW),
      .WIDTH (WORD_BITS)
    ) u_bank (
      .clk        (clk),
      .scan_en_in (scan_en_in),
      .i_ceb      (~w_req.en),
      .i_web      (~w_req.we),
      .i_a        (w_req.row[BANK_AW-1:0]),
      .i_d        (w_req.data[WORD_BITS-1:0]),
      .i_bweb     (w_bweb),
      .o_q        (w_bank_q[b])
    );
  end

  always_comb begin
    w_q_sel = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (r_rsp_bank == BANK_SEL_W'(b)) w_q_sel = w_bank_q[b];
    end
    if (r_rsp_oob) w_q_sel = '0;
  end

  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_data  = !r_rsp_valid ? '0 : (r_hold_valid ? r_hold_data : w_q_sel);
  assign addr_err     = r_addr_err;
  assign conflict_cnt = r_conflict_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_bank     <= '0;
      r_rsp_oob      <= 1'b0;
      r_hold_valid   <= 1'b0;
      r_hold_data    <= '0;
      r_wr_loss      <= '0;
      r_rd_loss      <= '0;
      r_addr_err     <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_bank   <= w_rd_bank;
        r_rsp_oob    <= w_rd_oob;
        r_hold_valid <= 1'b0;
      end else if (rd_rsp_ready) begin
        r_rsp_valid  <= 1'b0;
        r_hold_valid <= 1'b0;
      end else if (r_rsp_valid && !r_hold_valid) begin
        // First stalled edge: freeze the word so later bank traffic can't disturb it.
        r_hold_valid <= 1'b1;
        r_hold_data  <= w_q_sel;
      end

      if (!wr_valid || w_wr_acc)                            r_wr_loss <= '0;
      else if (w_conflict && w_rd_wins && r_wr_loss < LOSS_MAX) r_wr_loss <= r_wr_loss + 1'b1;

      if (!rd_req_valid || w_rd_acc)                         r_rd_loss <= '0;
      else if (w_conflict && !w_rd_wins && r_rd_loss < LOSS_MAX) r_rd_loss <= r_rd_loss + 1'b1;

      if ((w_wr_acc && w_wr_oob) || (w_rd_acc && w_rd_oob)) r_addr_err <= 1'b1;

      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_w_mem_banked_ctrl.sv
module tb_w_mem_banked_ctrl;

  localparam int NB = 3;
  localparam int BW = 16;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_en_in = 1'b0;
  logic        rd_priority = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_req_valid = 1'b0;
  logic        rd_req_ready;
  logic [5:0]  rd_addr = '0;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready = 1'b1;
  logic [31:0] rd_rsp_data;
  logic        addr_err;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  w_mem_banked_ctrl #(
    .N_BANKS      (NB),
    .BANK_WORDS   (BW),
    .WORD_BITS    (32),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_en_in   (scan_en_in),
    .rd_priority  (rd_priority),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .addr_err     (addr_err),
    .conflict_cnt (conflict_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: memory image, pending response, guard counters, flags.
  logic [31:0] mem_m [NB][BW];
  bit          m_rsp_v;
  logic [31:0] m_rsp_d;
  int          m_wr_loss, m_rd_loss, m_conf;
  bit          m_err;

  // Values observed at the most recent step, for directed checks.
  logic        o_wrdy, o_rrdy, o_rsp_v, o_err;
  logic [31:0] o_rsp_d;
  logic [15:0] o_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] mk_addr(input int b, input int r);
    return {2'(b), 4'(r)};
  endfunction

  // One clock: drive inputs, check all outputs against the model, clock, update model.
  task automatic step(input logic wv, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] wbe, input logic rv, input logic [5:0] ra,
                      input logic rrdy);
    int wb, wrow, rb, rrow;
    bit conflict, rd_wins, stall, e_wrdy, e_rrdy, wacc, racc;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_req_valid = rv; rd_addr = ra; rd_rsp_ready = rrdy;
    #2;
    wb = int'(wa) / BW; wrow = int'(wa) % BW;
    rb = int'(ra) / BW; rrow = int'(ra) % BW;
    stall    = m_rsp_v && !rrdy;
    conflict = wv && rv && (wb == rb);
    if (m_wr_loss >= SL)      rd_wins = 1'b0;
    else if (m_rd_loss >= SL) rd_wins = 1'b1;
    else                      rd_wins = rd_priority;
    e_wrdy = !(conflict && rd_wins);
    e_rrdy = !stall && !(conflict && !rd_wins);

    o_wrdy = wr_ready; o_rrdy = rd_req_ready; o_rsp_v = rd_rsp_valid;
    o_rsp_d = rd_rsp_data; o_err = addr_err; o_conf = conflict_cnt;
    chk("wr_ready", 32'(o_wrdy), 32'(e_wrdy));
    chk("rd_req_ready", 32'(o_rrdy), 32'(e_rrdy));
    chk("rd_rsp_valid", 32'(o_rsp_v), 32'(m_rsp_v));
    chk("rd_rsp_data", o_rsp_d, m_rsp_v ? m_rsp_d : 32'h0);
    chk("addr_err", 32'(o_err), 32'(m_err));
    chk("conflict_cnt", 32'(o_conf), 32'(m_conf));

    @(posedge clk);
    wacc = wv && e_wrdy;
    racc = rv && e_rrdy;
    if (racc) begin
      m_rsp_v = 1'b1;
      if (rb < NB) m_rsp_d = mem_m[rb][rrow];
      else         m_rsp_d = 32'h0;
    end else if (rrdy) begin
      m_rsp_v = 1'b0;
    end
    if (wacc && wb < NB)
      for (int j = 0; j < 4; j++)
        if (wbe[j]) mem_m[wb][wrow][8*j +: 8] = wd[8*j +: 8];
    if ((wacc && wb >= NB) || (racc && rb >= NB)) m_err = 1'b1;
    if (conflict && m_conf < 65535) m_conf++;
    if (!wv || wacc)                        m_wr_loss = 0;
    else if (conflict && rd_wins && m_wr_loss < SL) m_wr_loss++;
    if (!rv || racc)                        m_rd_loss = 0;
    else if (conflict && !rd_wins && m_rd_loss < SL) m_rd_loss++;
    #1;
  endtask

  task automatic idle(input logic rrdy);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, rrdy);
  endtask

  // Asynchronous reset applied away from the clock edge; memory is retained.
  task automatic do_reset(input string tag);
    wr_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    reset = 1'b0;
    #2;
    chk({tag, "_rsp_valid"}, 32'(rd_rsp_valid), 32'h0);
    chk({tag, "_rsp_data"}, rd_rsp_data, 32'h0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, "_conflict_cnt"}, 32'(conflict_cnt), 32'h0);
    m_rsp_v = 1'b0; m_rsp_d = '0; m_wr_loss = 0; m_rd_loss = 0; m_conf = 0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_addr();
    int b;
    b = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    return mk_addr(b, int'($urandom_range(0, BW - 1)));
  endfunction

  initial begin
    logic [31:0] prior;
    logic [5:0]  rrdy_pat, wrdy_pat;

    do_reset("reset");

    // Known contents everywhere so every read has a defined expectation.
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < BW; r++)
        step(1'b1, mk_addr(b, r), $urandom, 4'hF, 1'b0, 6'd0, 1'b1);

    // Full write then read.
    step(1'b1, mk_addr(1, 5), 32'hDEADBEEF, 4'hF, 1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(1, 5), 1'b1);
    idle(1'b1);
    chk("tp1_rsp_valid", 32'(o_rsp_v), 32'h1);
    chk("tp1_rsp_data", o_rsp_d, 32'hDEADBEEF);

    // Byte-masked overwrite.
    step(1'b1, mk_addr(0, 7), 32'h11223344, 4'hF, 1'b0, 6'd0, 1'b1);
    step(1'b1, mk_addr(0, 7), 32'hAABBCCDD, 4'b0101, 1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(0, 7), 1'b1);
    idle(1'b1);
    chk("tp2_masked_data", o_rsp_d, 32'h11BB33DD);

    // Different banks in the same cycle.
    prior = mem_m[1][9];
    step(1'b1, mk_addr(0, 3), 32'h5A5A0303, 4'hF, 1'b1, mk_addr(1, 9), 1'b1);
    chk("tp3_wr_ready", 32'(o_wrdy), 32'h1);
    chk("tp3_rd_ready", 32'(o_rrdy), 32'h1);
    idle(1'b1);
    chk("tp3_rsp_data", o_rsp_d, prior);

    // Starvation guard: read loses four times, wins the fifth, then loses again.
    do_reset("reset2");
    rd_priority = 1'b0;
    rrdy_pat = '0; wrdy_pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk_addr(2, 2), 32'hC0FFEE00, 4'hF, 1'b1, mk_addr(2, 1), 1'b1);
      rrdy_pat[i] = o_rrdy;
      wrdy_pat[i] = o_wrdy;
    end
    chk("tp4_rd_ready_pattern", 32'(rrdy_pat), 32'h10);
    chk("tp4_wr_ready_pattern", 32'(wrdy_pat), 32'h2F);
    idle(1'b1);
    chk("tp4_conflict_cnt", 32'(o_conf), 32'd6);

    // Stalled response must not change while the same word is rewritten.
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(1, 5), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk_addr(1, 5), 32'h0BADF00D, 4'hF, 1'b0, 6'd0, 1'b0);
      chk("tp5_stall_data", o_rsp_d, 32'hDEADBEEF);
      chk("tp5_stall_rd_ready", 32'(o_rrdy), 32'h0);
    end
    idle(1'b1);
    chk("tp5_consume_data", o_rsp_d, 32'hDEADBEEF);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(1, 5), 1'b1);
    idle(1'b1);
    chk("tp5_new_data", o_rsp_d, 32'h0BADF00D);

    // Out-of-range bank, then reset with a response pending.
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(3, 2), 1'b1);
    idle(1'b1);
    chk("tp6_rsp_valid", 32'(o_rsp_v), 32'h1);
    chk("tp6_rsp_data", o_rsp_d, 32'h0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, mk_addr(0, 7), 1'b0);
    chk("tp6_addr_err", 32'(o_err), 32'h1);
    do_reset("midreset");
    idle(1'b1);
    chk("tp6_dropped_rsp", 32'(o_rsp_v), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rd_priority = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), rand_addr(), $urandom, 4'($urandom),
           1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
